// File: rtl/dtc_tree_walker_if.sv
// Handshake and configuration bundle between a feature producer/class consumer
// and the sequential decision-tree walker.
interface dtc_tree_walker_if #(
   parameter int IN_W    = 10,
   parameter int FEAT_W  = 4,
   parameter int NODE_AW = 4
) ();
   localparam int ENTRY_W = 2 + FEAT_W + 2 * NODE_AW;

   logic               cfg_we;
   logic [NODE_AW-1:0] cfg_addr;
   logic [ENTRY_W-1:0] cfg_wdata;
   logic               in_valid;
   logic               in_ready;
   logic [IN_W-1:0]    inp;
   logic               out_valid;
   logic               out_ready;
   logic               outp;
   logic               out_err;
   logic               busy;

   modport slave (
      input  cfg_we, cfg_addr, cfg_wdata, in_valid, inp, out_ready,
      output in_ready, out_valid, outp, out_err, busy
   );

   modport master (
      output cfg_we, cfg_addr, cfg_wdata, in_valid, inp, out_ready,
      input  in_ready, out_valid, outp, out_err, busy
   );
endinterface

// File: rtl/dtc_tree_walker.sv
// Walks a run-time-loadable binary decision tree one node per clock and
// returns a 1-bit class, flagging step-limit or bad-feature walks as errors.
module dtc_tree_walker #(
   parameter int IN_W      = 10,
   parameter int FEAT_W    = 4,
   parameter int NODE_AW   = 4,
   parameter int MAX_STEPS = 8
) (
   input  logic              clk,
   input  logic              rst,
   dtc_tree_walker_if.slave  bus
);
   localparam int ENTRY_W = 2 + FEAT_W + 2 * NODE_AW;
   localparam int NODES   = 1 << NODE_AW;
   localparam int FEAT_N  = 1 << FEAT_W;
   localparam logic [ENTRY_W-1:0] RESET_ENTRY = {1'b1, {(ENTRY_W-1){1'b0}}};
   localparam logic [7:0] STEP_LAST = 8'(MAX_STEPS - 1);

   typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

   state_t             state_reg, state_next;
   logic [IN_W-1:0]    inp_reg, inp_next;
   logic [NODE_AW-1:0] cur_reg, cur_next;
   logic [7:0]         steps_reg, steps_next;
   logic               outp_reg, outp_next;
   logic               err_reg, err_next;

   logic [ENTRY_W-1:0] table_reg [NODES];
   logic               tbl_we;
   logic               accept;

   logic [ENTRY_W-1:0] node;
   logic               node_leaf;
   logic               node_val;
   logic [FEAT_W-1:0]  node_feat;
   logic [NODE_AW-1:0] node_lo;
   logic [NODE_AW-1:0] node_hi;
   logic [FEAT_N-1:0]  inp_ext;
   logic               feat_bad;
   logic [NODE_AW-1:0] next_node;

   // The table only accepts writes while idle so a walk always sees a stable tree.
   assign tbl_we = (state_reg == IDLE) && bus.cfg_we;

   generate
      for (genvar gi = 0; gi < NODES; gi++) begin : g_table
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               table_reg[gi] <= RESET_ENTRY;
            end else if (tbl_we && (bus.cfg_addr == NODE_AW'(gi))) begin
               table_reg[gi] <= bus.cfg_wdata;
            end
         end
      end
   endgenerate

   assign node      = table_reg[cur_reg];
   assign node_leaf = node[ENTRY_W-1];
   assign node_val  = node[ENTRY_W-2];
   assign node_feat = node[2*NODE_AW +: FEAT_W];
   assign node_lo   = node[NODE_AW +: NODE_AW];
   assign node_hi   = node[0 +: NODE_AW];

   // Zero-extend the vector so an out-of-range feature index still reads a defined bit.
   assign inp_ext   = FEAT_N'(inp_reg);
   assign feat_bad  = int'(node_feat) >= IN_W;
   assign next_node = inp_ext[node_feat] ? node_hi : node_lo;

   assign bus.in_ready  = !rst && (state_reg == IDLE) && !bus.cfg_we;
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = (state_reg == DONE);
   assign bus.busy      = (state_reg != IDLE);
   assign bus.outp      = outp_reg;
   assign bus.out_err   = err_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         inp_reg   <= '0;
         cur_reg   <= '0;
         steps_reg <= '0;
         outp_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         inp_reg   <= inp_next;
         cur_reg   <= cur_next;
         steps_reg <= steps_next;
         outp_reg  <= outp_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      inp_next   = inp_reg;
      cur_next   = cur_reg;
      steps_next = steps_reg;
      outp_next  = outp_reg;
      err_next   = err_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               inp_next   = bus.inp;
               cur_next   = '0;
               steps_next = '0;
               state_next = WALK;
            end
         end
         WALK: begin
            if (node_leaf) begin
               outp_next  = node_val;
               err_next   = 1'b0;
               state_next = DONE;
            end else if (feat_bad || (steps_reg == STEP_LAST)) begin
               outp_next  = 1'b0;
               err_next   = 1'b1;
               state_next = DONE;
            end else begin
               cur_next   = next_node;
               steps_next = steps_reg + 8'd1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_dtc_tree_walker.sv
// Directed bench for dtc_tree_walker: table-driven classification vectors plus
// hand-written sequences for step limit, bad feature, consumer stall and reset.
module tb_dtc_tree_walker;
   localparam int IN_W    = 10;
   localparam int FEAT_W  = 4;
   localparam int NODE_AW = 4;
   localparam int ENTRY_W = 2 + FEAT_W + 2 * NODE_AW;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   dtc_tree_walker_if #(.IN_W(IN_W), .FEAT_W(FEAT_W), .NODE_AW(NODE_AW)) dut_if ();

   dtc_tree_walker #(.IN_W(IN_W), .FEAT_W(FEAT_W), .NODE_AW(NODE_AW), .MAX_STEPS(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dut_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [IN_W-1:0] v;
      logic            eo;
      logic            ee;
      int              lat;
   } vec_t;

   function automatic logic [ENTRY_W-1:0] mk(input logic lf, input logic lv,
                                              input int f, input int lo, input int hi);
      return {lf, lv, FEAT_W'(f), NODE_AW'(lo), NODE_AW'(hi)};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cfg_write(input int addr, input logic [ENTRY_W-1:0] data);
      @(negedge clk);
      dut_if.cfg_we    = 1'b1;
      dut_if.cfg_addr  = NODE_AW'(addr);
      dut_if.cfg_wdata = data;
      @(negedge clk);
      dut_if.cfg_we    = 1'b0;
   endtask

   // One classification; during a stall of `hold` cycles the bench also pulses
   // cfg_we, which must not reach the table.
   task automatic run(input string name, input logic [IN_W-1:0] v, input int hold,
                      input logic eo, input logic ee, input int elat);
      int   guard;
      int   lat;
      logic o;
      logic e;
      guard = 0;
      @(negedge clk);
      while (!dut_if.in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check({name, "_ready"}, int'(dut_if.in_ready), 1);
      dut_if.in_valid = 1'b1;
      dut_if.inp      = v;
      @(posedge clk);
      @(negedge clk);
      dut_if.in_valid = 1'b0;
      dut_if.inp      = ~v;
      lat = 0;
      while (!dut_if.out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      o = dut_if.outp;
      e = dut_if.out_err;
      check({name, "_valid"}, int'(dut_if.out_valid), 1);
      check({name, "_outp"}, int'(o), int'(eo));
      check({name, "_err"}, int'(e), int'(ee));
      check({name, "_lat"}, lat, elat);
      for (int i = 0; i < hold; i++) begin
         dut_if.cfg_we    = 1'b1;
         dut_if.cfg_addr  = '0;
         dut_if.cfg_wdata = mk(1'b1, 1'b0, 0, 0, 0);
         @(negedge clk);
         check({name, "_hold_valid"}, int'(dut_if.out_valid), 1);
         check({name, "_hold_outp"}, int'(dut_if.outp), int'(o));
         check({name, "_hold_ready"}, int'(dut_if.in_ready), 0);
      end
      dut_if.cfg_we    = 1'b0;
      dut_if.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dut_if.out_ready = 1'b0;
      check({name, "_drop_valid"}, int'(dut_if.out_valid), 0);
      check({name, "_keep_outp"}, int'(dut_if.outp), int'(o));
      $display("run %s inp=0x%03h outp=%0d err=%0d lat=%0d", name, v, o, e, lat);
   endtask

   vec_t vecs[6];
   logic [ENTRY_W-1:0] tree[9];

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      dut_if.cfg_we    = 1'b0;
      dut_if.cfg_addr  = '0;
      dut_if.cfg_wdata = '0;
      dut_if.in_valid  = 1'b0;
      dut_if.inp       = '0;
      dut_if.out_ready = 1'b0;

      tree[0] = mk(1'b0, 1'b0, 1, 1, 2);
      tree[1] = mk(1'b0, 1'b0, 0, 3, 4);
      tree[2] = mk(1'b0, 1'b0, 0, 5, 6);
      tree[3] = mk(1'b0, 1'b0, 3, 7, 8);
      tree[4] = mk(1'b1, 1'b1, 0, 0, 0);
      tree[5] = mk(1'b0, 1'b0, 2, 8, 7);
      tree[6] = mk(1'b1, 1'b0, 0, 0, 0);
      tree[7] = mk(1'b1, 1'b1, 0, 0, 0);
      tree[8] = mk(1'b1, 1'b0, 0, 0, 0);

      vecs[0] = '{v: 10'h000, eo: 1'b1, ee: 1'b0, lat: 4};
      vecs[1] = '{v: 10'h008, eo: 1'b0, ee: 1'b0, lat: 4};
      vecs[2] = '{v: 10'h002, eo: 1'b0, ee: 1'b0, lat: 4};
      vecs[3] = '{v: 10'h006, eo: 1'b1, ee: 1'b0, lat: 4};
      vecs[4] = '{v: 10'h003, eo: 1'b0, ee: 1'b0, lat: 3};
      vecs[5] = '{v: 10'h001, eo: 1'b1, ee: 1'b0, lat: 3};

      // Reset values while rst is held.
      repeat (2) @(negedge clk);
      check("rst_in_ready", int'(dut_if.in_ready), 0);
      check("rst_out_valid", int'(dut_if.out_valid), 0);
      check("rst_busy", int'(dut_if.busy), 0);
      check("rst_outp", int'(dut_if.outp), 0);
      check("rst_err", int'(dut_if.out_err), 0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", int'(dut_if.in_ready), 1);

      // Unconfigured table: root is a leaf with value 0.
      run("fresh", 10'h3FF, 0, 1'b0, 1'b0, 1);

      for (int i = 0; i < 9; i++) cfg_write(i, tree[i]);
      // cfg_we blocks acceptance in the same cycle.
      @(negedge clk);
      dut_if.cfg_we    = 1'b1;
      dut_if.cfg_addr  = 4'd15;
      dut_if.cfg_wdata = mk(1'b1, 1'b0, 0, 0, 0);
      #1;
      check("cfg_blocks_ready", int'(dut_if.in_ready), 0);
      @(negedge clk);
      dut_if.cfg_we = 1'b0;

      for (int i = 0; i < 6; i++) run($sformatf("vec%0d", i), vecs[i].v, 0,
                                      vecs[i].eo, vecs[i].ee, vecs[i].lat);

      // Consumer stall with ignored cfg writes, then confirm the table is intact.
      run("hold", 10'h000, 5, 1'b1, 1'b0, 4);
      run("after_hold", 10'h000, 0, 1'b1, 1'b0, 4);

      cfg_write(0, mk(1'b0, 1'b0, 0, 0, 0));
      run("selfloop_a", 10'h155, 0, 1'b0, 1'b1, 8);
      run("selfloop_b", 10'h2AA, 0, 1'b0, 1'b1, 8);

      cfg_write(0, mk(1'b0, 1'b0, 12, 1, 1));
      run("badfeat", 10'h000, 0, 1'b0, 1'b1, 1);

      // Asynchronous reset in the middle of a walk.
      cfg_write(0, tree[0]);
      @(negedge clk);
      dut_if.in_valid = 1'b1;
      dut_if.inp      = 10'h000;
      @(posedge clk);
      @(negedge clk);
      dut_if.in_valid = 1'b0;
      check("walk_busy", int'(dut_if.busy), 1);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_valid", int'(dut_if.out_valid), 0);
      check("midrst_busy", int'(dut_if.busy), 0);
      check("midrst_in_ready", int'(dut_if.in_ready), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_release_ready", int'(dut_if.in_ready), 1);
      check("midrst_release_busy", int'(dut_if.busy), 0);
      run("after_midrst", 10'h000, 0, 1'b0, 1'b0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
